// File: rtl/alu_pkg.sv
// Shared ALU result types.
// Used by the result logger and the ALU/FSM top.
package alu_pkg;

   localparam int DATA_W = 5;

   typedef struct packed {
      logic              zf;
      logic [DATA_W-1:0] r;
   } alu_res_t;

endpackage

// File: rtl/res_fifo.sv
// Result FIFO: storage, pointers and occupancy.
// Head is shown the cycle after it is written.
module res_fifo
   import alu_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type T     = alu_res_t,
   localparam int PW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  T              push_data,
   input  logic          pop_req,
   output logic          push_ok,
   output logic          drop,
   output logic          pop,
   output T              head,
   output logic          head_valid,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   T              mem [DEPTH];

   assign full       = (level == LW'(DEPTH));
   assign empty      = (level == '0);
   assign head_valid = !empty;
   assign pop        = head_valid && pop_req;
   // a pop frees the slot this cycle, so a full FIFO can still accept
   assign push_ok    = push && (!full || pop);
   assign drop       = push && full && !pop;
   assign head       = empty ? T'('0) : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/alu_result_log.sv
// Buffers sampled ALU results for a consumer,
// with saturating statistics and sticky error flags.
module alu_result_log
   import alu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_r,
   input  logic                       in_zf,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_r,
   output logic                       out_zf,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty,
   input  logic                       clr_flags,
   output logic                       overflow,
   output logic                       zf_err,
   output logic [CNT_W-1:0]           total_cnt,
   output logic [CNT_W-1:0]           zero_cnt
);

   alu_res_t wr_d;
   alu_res_t rd_d;
   logic     push_ok;
   logic     drop;
   logic     pop;
   logic     zf_bad;

   assign wr_d   = '{zf: in_zf, r: in_r};
   assign out_r  = rd_d.r;
   assign out_zf = rd_d.zf;
   assign zf_bad = in_zf != (in_r == '0);

   res_fifo #(
      .DEPTH (DEPTH),
      .T     (alu_res_t)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (in_valid),
      .push_data  (wr_d),
      .pop_req    (out_ready),
      .push_ok    (push_ok),
      .drop       (drop),
      .pop        (pop),
      .head       (rd_d),
      .head_valid (out_valid),
      .level      (level),
      .full       (full),
      .empty      (empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         total_cnt <= '0;
         zero_cnt  <= '0;
      end else if (push_ok) begin
         if (total_cnt != '1)
            total_cnt <= total_cnt + CNT_W'(1);
         if (in_zf && zero_cnt != '1)
            zero_cnt <= zero_cnt + CNT_W'(1);
      end
   end

   // a new set event in the clearing cycle keeps the flag up
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         zf_err   <= 1'b0;
      end else begin
         if (drop)
            overflow <= 1'b1;
         else if (clr_flags)
            overflow <= 1'b0;
         if (push_ok && zf_bad)
            zf_err <= 1'b1;
         else if (clr_flags)
            zf_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_result_log.sv
// Directed vector bench for alu_result_log.
// DEPTH=8, CNT_W=4 so counter saturation is reachable.
module tb_alu_result_log;

   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [4:0] in_r = '0;
   logic       in_zf = 1'b0;
   logic       out_ready = 1'b0;
   logic       clr_flags = 1'b0;
   logic       out_valid;
   logic [4:0] out_r;
   logic       out_zf;
   logic [3:0] level;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       zf_err;
   logic [CNT_W-1:0] total_cnt;
   logic [CNT_W-1:0] zero_cnt;

   typedef struct packed {
      logic       ov;
      logic [4:0] r;
      logic       zf;
      logic [3:0] lvl;
      logic       fu;
      logic       em;
      logic       of;
      logic       ze;
      logic [3:0] tot;
      logic [3:0] zr;
   } obs_t;

   typedef struct packed {
      logic       pre_rst;
      logic       iv;
      logic [4:0] r;
      logic       zf;
      logic       rdy;
      logic       clr;
      obs_t       exp;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   vec_t vq[$];

   alu_result_log #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_r      (in_r),
      .in_zf     (in_zf),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_r     (out_r),
      .out_zf    (out_zf),
      .level     (level),
      .full      (full),
      .empty     (empty),
      .clr_flags (clr_flags),
      .overflow  (overflow),
      .zf_err    (zf_err),
      .total_cnt (total_cnt),
      .zero_cnt  (zero_cnt)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(int ov, int r, int zf, int lvl, int fu,
                               int em, int of, int ze, int tot, int zr);
      obs_t o;
      o.ov  = 1'(ov);
      o.r   = 5'(r);
      o.zf  = 1'(zf);
      o.lvl = 4'(lvl);
      o.fu  = 1'(fu);
      o.em  = 1'(em);
      o.of  = 1'(of);
      o.ze  = 1'(ze);
      o.tot = 4'(tot);
      o.zr  = 4'(zr);
      return o;
   endfunction

   function automatic obs_t cur();
      return {out_valid, out_r, out_zf, level, full, empty,
              overflow, zf_err, total_cnt, zero_cnt};
   endfunction

   task automatic chk(string nm, obs_t e);
      obs_t a;
      a = cur();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, a, e);
      end
   endtask

   task automatic drive(logic iv, int r, logic zf, logic rdy, logic clr);
      in_valid  = iv;
      in_r      = 5'(r);
      in_zf     = zf;
      out_ready = rdy;
      clr_flags = clr;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
   endtask

   task automatic add(logic pre, logic iv, int r, logic zf,
                      logic rdy, logic clr, obs_t e);
      vec_t v;
      v.pre_rst = pre;
      v.iv      = iv;
      v.r       = 5'(r);
      v.zf      = zf;
      v.rdy     = rdy;
      v.clr     = clr;
      v.exp     = e;
      vq.push_back(v);
   endtask

   initial begin
      // first write after reset
      add(1, 1, 0, 1, 0, 0, mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 1));
      // fill 1..8, drop 9th, drain
      for (int k = 1; k <= 8; k++)
         add(k == 1, 1, k, 0, 0, 0,
             mk(1, 1, 0, k, k == 8, 0, 0, 0, k, 0));
      add(0, 1, 9, 0, 0, 0, mk(1, 1, 0, 8, 1, 0, 1, 0, 8, 0));
      for (int j = 1; j <= 8; j++)
         add(0, 0, 0, 0, 1, 0,
             mk(j < 8, (j < 8) ? j + 1 : 0, 0, 8 - j, 0, j == 8,
                1, 0, 8, 0));
      add(0, 0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 1, 0, 0, 8, 0));
      // inconsistent zero flag and clear priority
      add(1, 1, 3, 1, 0, 0, mk(1, 3, 1, 1, 0, 0, 0, 1, 1, 1));
      add(0, 0, 0, 0, 0, 1, mk(1, 3, 1, 1, 0, 0, 0, 0, 1, 1));
      add(0, 1, 0, 0, 0, 1, mk(1, 3, 1, 2, 0, 0, 0, 1, 2, 1));
      add(0, 1, 5, 0, 0, 0, mk(1, 3, 1, 3, 0, 0, 0, 1, 3, 1));
      // pop while empty
      add(1, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

      do_reset();
      chk("reset", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

      foreach (vq[i]) begin
         if (vq[i].pre_rst)
            do_reset();
         drive(vq[i].iv, vq[i].r, vq[i].zf, vq[i].rdy, vq[i].clr);
         cyc();
         chk($sformatf("vec%0d", i), vq[i].exp);
      end

      // full with simultaneous pop and push
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         drive(1, k, 0, 0, 0);
         cyc();
      end
      chk("fill8", mk(1, 1, 0, 8, 1, 0, 0, 0, 8, 0));
      drive(1, 9, 0, 1, 0);
      cyc();
      chk("full_push_pop", mk(1, 2, 0, 8, 1, 0, 0, 0, 9, 0));
      for (int m = 1; m <= 8; m++) begin
         drive(0, 0, 0, 1, 0);
         cyc();
         chk($sformatf("drain%0d", m),
             mk(m < 8, (m < 8) ? m + 2 : 0, 0, 8 - m, 0, m == 8,
                0, 0, 9, 0));
      end

      // saturation while streaming
      do_reset();
      drive(1, 0, 1, 1, 0);
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (i == 15 || i == 20)
            chk($sformatf("sat%0d", i),
                mk(1, 0, 1, 1, 0, 0, 0, 0, 15, 15));
      end

      // asynchronous reset mid-stream
      do_reset();
      drive(1, 7, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         cyc();
      chk("pre_async", mk(1, 7, 0, 5, 0, 0, 0, 0, 5, 0));
      drive(0, 0, 0, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      cyc();
      reset = 1'b1;
      drive(1, 4, 0, 0, 0);
      #1;
      chk("post_rst_idle", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      cyc();
      chk("post_rst_wr", mk(1, 4, 0, 1, 0, 0, 0, 0, 1, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
